// File: rtl/uart_top_8n1.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one
// clock and one bit-period counter limit. The TX and RX state machines each
// run as a two-process FSM.
module uart_top_8n1 #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_din,
    input  logic [7:0] tx_data,
    input  logic       tx_send,
    output logic       tx_dout,
    output logic       tx_active,
    output logic [7:0] rx_data,
    output logic       rx_data_ready
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;

    // TX state register; reset drops any frame in flight and idles the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // TX next state: each of start, 8 data and stop bits lasts CLKS_PER_BIT clocks.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_dout    = 1'b1;
        tx_active  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                // Requests are only honoured here, so a send while busy is dropped.
                if (tx_send) begin
                    tx_shift_d = tx_data;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_dout   = 1'b0;
                tx_active = 1'b1;
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                tx_dout   = tx_shift_q[0];
                tx_active = 1'b1;
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                tx_active = 1'b1;
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_ready_q, rx_ready_d;

    // RX registers; synchronizer and edge-detect flops reset to the idle-high level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= 8'h00;
            rx_ready_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    // RX next state: qualify the start bit at half a bit, then sample mid-bit.
    always_comb begin
        rx_meta_d  = rx_din;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_ready_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                // Only a real 1->0 transition starts a frame. After a framing
                // error the line may still be low; no edge is seen until it
                // has returned high, which gives the wait-for-idle behaviour.
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    // A line already back high here was a glitch.
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    // A low stop bit discards the byte and leaves rx_data alone.
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_ready_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_data       = rx_data_q;
    assign rx_data_ready = rx_ready_q;

endmodule

// File: tb/tb_uart_top_8n1.sv
// Self-checking bench for uart_top_8n1: loopback traffic, TX waveform timing,
// busy-send rejection, mid-frame reset, framing error and start-bit glitch.
module tb_uart_top_8n1;

    localparam int CPB   = 16;
    localparam int LIMIT = 30 * CPB;

    logic       clk;
    logic       rst;
    logic       rx_din;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_dout;
    logic       tx_active;
    logic [7:0] rx_data;
    logic       rx_data_ready;

    logic       loop_en;
    logic       rx_drv;

    int checks;
    int errors;
    int pulse_cnt;

    logic [7:0] exp_q[$];

    uart_top_8n1 #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(62_500)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_din       (rx_din),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_dout      (tx_dout),
        .tx_active    (tx_active),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready)
    );

    assign rx_din = loop_en ? tx_dout : rx_drv;

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every ready pulse must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst && rx_data_ready === 1'b1) begin
            logic [7:0] exp;
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: rx_data=%02h, no byte expected", rx_data);
            end else begin
                exp = exp_q.pop_front();
                if (rx_data !== exp) begin
                    errors++;
                    $display("FAIL rx_byte: got %02h expected %02h", rx_data, exp);
                end
            end
        end
    end

    // Driver tasks (called at a negedge)
    task automatic send_byte(input logic [7:0] b, input bit expect_rx);
        tx_data = b;
        tx_send = 1'b1;
        if (expect_rx) exp_q.push_back(b);
        @(negedge clk);
        tx_send = 1'b0;
    endtask

    task automatic wait_tx_done(input string name);
        int n;
        n = 0;
        while (tx_active === 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: tx_active still %b after %0d cycles", name, tx_active, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic measure_run(input logic level, input bit need_active, output int len);
        len = 0;
        while (tx_dout === level && (!need_active || tx_active === 1'b1) && len < LIMIT) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Tests
    task automatic test_reset();
        rst     = 1'b1;
        loop_en = 1'b1;
        rx_drv  = 1'b1;
        tx_data = 8'h00;
        tx_send = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (tx_dout !== 1'b1) begin errors++; $display("FAIL reset_tx_dout: got %b expected 1", tx_dout); end
        if (tx_active !== 1'b0) begin errors++; $display("FAIL reset_tx_active: got %b expected 0", tx_active); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %02h expected 00", rx_data); end
        if (rx_data_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b expected 0", rx_data_ready); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loopback_aa();
        int p0;
        int n;
        p0 = pulse_cnt;
        send_byte(8'hAA, 1'b1);
        n = 0;
        while (tx_active === 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks += 3;
        if (n !== 10 * CPB) begin errors++; $display("FAIL aa_active_len: got %0d expected %0d", n, 10 * CPB); end
        if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL aa_pulses: got %0d expected 1", pulse_cnt - p0); end
        if (rx_data !== 8'hAA) begin errors++; $display("FAIL aa_rx_data: got %02h expected aa", rx_data); end
    endtask

    task automatic test_waveform_01();
        int len;
        send_byte(8'h01, 1'b1);
        checks += 5;
        measure_run(1'b0, 1'b1, len);
        if (len !== CPB) begin errors++; $display("FAIL wave_start: got %0d expected %0d", len, CPB); end
        measure_run(1'b1, 1'b1, len);
        if (len !== CPB) begin errors++; $display("FAIL wave_bit0_high: got %0d expected %0d", len, CPB); end
        measure_run(1'b0, 1'b1, len);
        if (len !== 7 * CPB) begin errors++; $display("FAIL wave_bits1to7_low: got %0d expected %0d", len, 7 * CPB); end
        measure_run(1'b1, 1'b1, len);
        if (len !== CPB) begin errors++; $display("FAIL wave_stop: got %0d expected %0d", len, CPB); end
        if (tx_active !== 1'b0 || tx_dout !== 1'b1) begin
            errors++;
            $display("FAIL wave_idle: tx_active=%b tx_dout=%b expected 0/1", tx_active, tx_dout);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int p0;
        int n;
        p0 = pulse_cnt;
        send_byte(8'h00, 1'b1);
        n = 0;
        while (tx_active === 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        // First negedge with tx_active low: request the next frame right away.
        send_byte(8'hFF, 1'b1);
        checks += 4;
        if (tx_active !== 1'b1) begin errors++; $display("FAIL b2b_accept: tx_active=%b expected 1", tx_active); end
        if (tx_dout !== 1'b0) begin errors++; $display("FAIL b2b_start_bit: tx_dout=%b expected 0", tx_dout); end
        wait_tx_done("b2b");
        if (pulse_cnt - p0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulse_cnt - p0); end
        if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_rx_data: got %02h expected ff", rx_data); end
    endtask

    task automatic test_ignore_busy();
        int p0;
        p0 = pulse_cnt;
        send_byte(8'h3C, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        send_byte(8'h55, 1'b0);
        wait_tx_done("busy");
        checks += 2;
        if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL busy_pulses: got %0d expected 1", pulse_cnt - p0); end
        if (rx_data !== 8'h3C) begin errors++; $display("FAIL busy_rx_data: got %02h expected 3c", rx_data); end
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        p0 = pulse_cnt;
        send_byte(8'h5A, 1'b0);
        repeat (5 * CPB + CPB / 2 - 1) @(negedge clk);
        rst = 1'b1;
        #1;
        checks += 4;
        if (tx_dout !== 1'b1) begin errors++; $display("FAIL midrst_tx_dout: got %b expected 1", tx_dout); end
        if (tx_active !== 1'b0) begin errors++; $display("FAIL midrst_tx_active: got %b expected 0", tx_active); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data: got %02h expected 00", rx_data); end
        if (rx_data_ready !== 1'b0) begin errors++; $display("FAIL midrst_rx_ready: got %b expected 0", rx_data_ready); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        checks++;
        if (pulse_cnt !== p0) begin errors++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", pulse_cnt - p0); end
        send_byte(8'hA5, 1'b1);
        wait_tx_done("midrst");
        checks += 2;
        if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL midrst_next_pulses: got %0d expected 1", pulse_cnt - p0); end
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL midrst_next_rx_data: got %02h expected a5", rx_data); end
    endtask

    task automatic test_rx_errors();
        int p0;
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (4) @(negedge clk);
        p0 = pulse_cnt;
        drive_rx_frame(8'h96, 1'b0);
        checks += 2;
        if (pulse_cnt !== p0) begin errors++; $display("FAIL ferr_pulse: got %0d pulses expected 0", pulse_cnt - p0); end
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_rx_data: got %02h expected a5", rx_data); end
        // Low glitch shorter than half a bit.
        rx_drv = 1'b0;
        repeat (CPB / 2 - 2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        checks += 2;
        if (pulse_cnt !== p0) begin errors++; $display("FAIL glitch_pulse: got %0d pulses expected 0", pulse_cnt - p0); end
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL glitch_rx_data: got %02h expected a5", rx_data); end
        // Randomised good frame afterwards proves the receiver recovered.
        begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            drive_rx_frame(b, 1'b1);
            checks += 2;
            if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL recover_pulses: got %0d expected 1", pulse_cnt - p0); end
            if (rx_data !== b) begin errors++; $display("FAIL recover_rx_data: got %02h expected %02h", rx_data, b); end
        end
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Sequence and report
    initial begin
        checks    = 0;
        errors    = 0;
        pulse_cnt = 0;
        rst       = 1'b1;
        loop_en   = 1'b1;
        rx_drv    = 1'b1;
        tx_data   = 8'h00;
        tx_send   = 1'b0;
        @(negedge clk);
        test_reset();
        test_loopback_aa();
        test_waveform_01();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        test_rx_errors();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: %0d bytes never received, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
